// File: rtl/winograd_pkg.sv
// winograd_pkg: shared widths, read latency and FSM state encoding for the Winograd filter-transform controller
package winograd_pkg;
    localparam int FILT_W  = 72;
    localparam int XFORM_W = 128;
    localparam int RD_LAT  = 1;
    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_XF, S_WR, S_DONE} state_t;
endpackage

// File: rtl/winograd_filter_xform_ctrl.sv
// winograd_filter_xform_ctrl: streams 3x3 filters from SRAM through the external Winograd transform into the transformed-filter buffer
module winograd_filter_xform_ctrl
    import winograd_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               abort,
    input  logic [CNT_W-1:0]   num_filters,
    input  logic [ADDR_W-1:0]  rd_base,
    input  logic [ADDR_W-1:0]  wr_base,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [FILT_W-1:0]  rd_data,
    output logic [FILT_W-1:0]  xf_filter,
    input  logic [XFORM_W-1:0] xf_result,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [XFORM_W-1:0] wr_data,
    output logic               busy,
    output logic               done
);
    state_t             state;
    logic [CNT_W-1:0]   n;
    logic [CNT_W-1:0]   idx;
    logic [ADDR_W-1:0]  rb;
    logic [ADDR_W-1:0]  wb;
    logic [CNT_W-1:0]   idx_nx;

    assign idx_nx = idx + CNT_W'(1);

    // rd_data arrives RD_LAT cycle after the RD strobe, so it is captured on leaving CAP
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            n         <= '0;
            idx       <= '0;
            rb        <= '0;
            wb        <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            xf_filter <= '0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_en <= 1'b0;
            done  <= 1'b0;
            if (abort && state != S_IDLE) begin
                state    <= S_IDLE;
                wr_valid <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        n    <= num_filters;
                        rb   <= rd_base;
                        wb   <= wr_base;
                        idx  <= '0;
                        busy <= 1'b1;
                        if (num_filters != '0) begin
                            state   <= S_RD;
                            rd_en   <= 1'b1;
                            rd_addr <= rd_base;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                    S_RD:  state <= S_CAP;
                    S_CAP: begin
                        xf_filter <= rd_data;
                        state     <= S_XF;
                    end
                    S_XF: begin
                        wr_data  <= xf_result;
                        wr_addr  <= wb + ADDR_W'(idx);
                        wr_valid <= 1'b1;
                        state    <= S_WR;
                    end
                    S_WR: if (wr_ready) begin
                        wr_valid <= 1'b0;
                        if (idx == n - CNT_W'(1)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            idx     <= idx_nx;
                            state   <= S_RD;
                            rd_en   <= 1'b1;
                            rd_addr <= rb + ADDR_W'(idx_nx);
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_winograd_filter_xform_ctrl.sv
// tb_winograd_filter_xform_ctrl: directed bench with SRAM and transform models around the controller
module tb_winograd_filter_xform_ctrl;
    logic         clk = 0, rstn = 0, start = 0, abort = 0, wr_ready = 0;
    logic [7:0]   num_filters = 0;
    logic [9:0]   rd_base = 0, wr_base = 0;
    logic         rd_en, wr_valid, busy, done;
    logic [9:0]   rd_addr, wr_addr;
    logic [71:0]  rd_data = 0, xf_filter;
    logic [127:0] xf_result, wr_data;
    int checks = 0, errors = 0, cyc = 0, acc = 0, nbusy = 0;
    int rd_cyc[$], wr_cyc[$], done_cyc[$];
    logic [9:0]   rd_q[$], wa_q[$];
    logic [127:0] wd_q[$];

    winograd_filter_xform_ctrl #(.ADDR_W(10), .CNT_W(8)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .num_filters(num_filters),
        .rd_base(rd_base), .wr_base(wr_base), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .xf_filter(xf_filter), .xf_result(xf_result), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
    );

    function automatic logic [71:0] sram(input logic [9:0] a);
        return a == 10'h010 ? 72'h4 :
            {a[7:0], 8'h11, 6'h0, a[9:8], 8'h03, 8'h07, 8'h02, 8'h01, 8'h05, a[7:0] ^ 8'h3C};
    endfunction

    // reference transform G g G^T with G scaled by 2, result divided by 4
    function automatic logic [127:0] xform(input logic [71:0] f);
        int G[4][3] = '{'{2, 0, 0}, '{1, 1, 1}, '{1, -1, 1}, '{0, 0, 2}};
        int t[4][3];
        int r;
        logic [127:0] o;
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < 3; c++) begin
                t[i][c] = 0;
                for (int k = 0; k < 3; k++) t[i][c] += G[i][k] * int'(f[8*(3*k+c) +: 8]);
            end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                r = 0;
                for (int c = 0; c < 3; c++) r += t[i][c] * G[j][c];
                o[8*(4*i+j) +: 8] = 8'(r >>> 2);
            end
        return o;
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rd_en) rd_data <= sram(rd_addr);
    always_comb xf_result = xform(xf_filter);

    initial forever begin
        @(negedge clk);
        #4;
        if (rd_en) begin rd_q.push_back(rd_addr); rd_cyc.push_back(cyc - acc + 1); end
        if (wr_valid && wr_ready) begin
            wa_q.push_back(wr_addr); wd_q.push_back(wr_data); wr_cyc.push_back(cyc - acc + 1);
        end
        if (done) done_cyc.push_back(cyc - acc + 1);
        if (busy) nbusy++;
    end

    task automatic go(input logic [7:0] n, input logic [9:0] rb, input logic [9:0] wb);
        @(negedge clk);
        rd_q.delete(); rd_cyc.delete(); wa_q.delete(); wd_q.delete(); wr_cyc.delete(); done_cyc.delete();
        nbusy = 0;
        num_filters = n; rd_base = rb; wr_base = wb; start = 1;
        @(negedge clk);
        start = 0;
        acc = cyc;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = done;
        for (int i = 0; i < budget; i++) if (!ok) begin @(negedge clk); ok = done; end
        @(negedge clk);
    endtask

    task automatic wait_wr(input int budget, input int prior, output bit ok);
        ok = wr_valid && wa_q.size() == prior;
        for (int i = 0; i < budget; i++) if (!ok) begin
            @(negedge clk);
            ok = wr_valid && wa_q.size() == prior;
        end
    endtask

    task automatic test_reset;
        rstn = 0;
        repeat (2) @(negedge clk);
        checks++; if ({rd_en, wr_valid, busy, done} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got %b want 0000", {rd_en, wr_valid, busy, done}); end
        checks++; if (rd_addr !== 10'h0 || wr_addr !== 10'h0) begin errors++; $display("FAIL reset_addr got %h/%h want 0/0", rd_addr, wr_addr); end
        checks++; if (wr_data !== 128'h0 || xf_filter !== 72'h0) begin errors++; $display("FAIL reset_data got %h/%h want 0/0", wr_data, xf_filter); end
        rstn = 1;
        @(negedge clk);
    endtask

    task automatic test_single;
        bit ok;
        wr_ready = 1;
        go(1, 10'h010, 10'h123);
        wait_done(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout got no done want done"); end
        checks++; if (rd_q.size() != 1 || rd_q[0] !== 10'h010 || rd_cyc[0] != 1) begin errors++; $display("FAIL single_rd got n=%0d addr=%h cyc=%0d want 1/010/1", rd_q.size(), rd_q[0], rd_cyc[0]); end
        checks++; if (wa_q.size() != 1 || wa_q[0] !== 10'h123 || wr_cyc[0] != 4) begin errors++; $display("FAIL single_wr got n=%0d addr=%h cyc=%0d want 1/123/4", wa_q.size(), wa_q[0], wr_cyc[0]); end
        checks++; if (wd_q[0] !== 128'h00000000_00010102_00010102_00020204) begin errors++; $display("FAIL single_data got %h want 00000000000101020001010200020204", wd_q[0]); end
        checks++; if (done_cyc.size() != 1 || done_cyc[0] != 5) begin errors++; $display("FAIL single_done got n=%0d cyc=%0d want 1/5", done_cyc.size(), done_cyc[0]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_multi;
        bit ok;
        wr_ready = 1;
        go(3, 10'h020, 10'h200);
        wait_done(30, ok);
        checks++; if (!ok || wa_q.size() != 3 || rd_q.size() != 3) begin errors++; $display("FAIL multi_count got done=%b wr=%0d rd=%0d want 1/3/3", ok, wa_q.size(), rd_q.size()); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (rd_q[k] !== 10'(32'h20 + k) || wa_q[k] !== 10'(32'h200 + k)) begin errors++; $display("FAIL multi_addr%0d got %h/%h want %h/%h", k, rd_q[k], wa_q[k], 10'(32'h20 + k), 10'(32'h200 + k)); end
            checks++; if (wd_q[k] !== xform(sram(10'(32'h20 + k)))) begin errors++; $display("FAIL multi_data%0d got %h want %h", k, wd_q[k], xform(sram(10'(32'h20 + k)))); end
            checks++; if (wr_cyc[k] != 4 + 4 * k) begin errors++; $display("FAIL multi_wrcyc%0d got %0d want %0d", k, wr_cyc[k], 4 + 4 * k); end
        end
        checks++; if (done_cyc.size() != 1 || done_cyc[0] != 13) begin errors++; $display("FAIL multi_done got n=%0d cyc=%0d want 1/13", done_cyc.size(), done_cyc[0]); end
    endtask

    task automatic test_backpressure;
        bit ok;
        logic [127:0] exp;
        exp = xform(sram(10'h040));
        wr_ready = 0;
        go(2, 10'h040, 10'h080);
        wait_wr(20, 0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got no wr_valid want wr_valid"); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (wr_valid !== 1'b1 || wr_addr !== 10'h080 || rd_en !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got v=%b a=%h rd=%b want 1/080/0", i, wr_valid, wr_addr, rd_en); end
            checks++; if (wr_data !== exp) begin errors++; $display("FAIL bp_data%0d got %h want %h", i, wr_data, exp); end
            @(negedge clk);
        end
        wr_ready = 1;
        wait_done(30, ok);
        checks++; if (!ok || wa_q.size() != 2 || wr_cyc[0] != 9 || rd_cyc[1] != 10) begin errors++; $display("FAIL bp_resume got done=%b wr=%0d wcyc=%0d rcyc=%0d want 1/2/9/10", ok, wa_q.size(), wr_cyc[0], rd_cyc[1]); end
    endtask

    task automatic test_zero;
        bit ok;
        go(0, 10'h055, 10'h066);
        wait_done(10, ok);
        checks++; if (!ok || done_cyc.size() != 1 || done_cyc[0] != 1) begin errors++; $display("FAIL zero_done got n=%0d cyc=%0d want 1/1", done_cyc.size(), done_cyc[0]); end
        checks++; if (rd_q.size() != 0 || wa_q.size() != 0) begin errors++; $display("FAIL zero_traffic got rd=%0d wr=%0d want 0/0", rd_q.size(), wa_q.size()); end
        checks++; if (nbusy != 1) begin errors++; $display("FAIL zero_busy got %0d want 1", nbusy); end
    endtask

    task automatic test_wrap;
        bit ok;
        wr_ready = 1;
        go(2, 10'h3FF, 10'h3FF);
        wait_done(20, ok);
        checks++; if (!ok || rd_q.size() != 2 || rd_q[0] !== 10'h3FF || rd_q[1] !== 10'h000) begin errors++; $display("FAIL wrap_rd got n=%0d %h %h want 2 3ff 000", rd_q.size(), rd_q[0], rd_q[1]); end
        checks++; if (wa_q.size() != 2 || wa_q[0] !== 10'h3FF || wa_q[1] !== 10'h000) begin errors++; $display("FAIL wrap_wr got n=%0d %h %h want 2 3ff 000", wa_q.size(), wa_q[0], wa_q[1]); end
        checks++; if (wd_q[1] !== xform(sram(10'h000))) begin errors++; $display("FAIL wrap_data got %h want %h", wd_q[1], xform(sram(10'h000))); end
    endtask

    task automatic test_abort;
        bit ok;
        wr_ready = 1;
        go(3, 10'h030, 10'h300);
        wait_wr(20, 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_timeout got no second WR want second WR"); end
        abort = 1;
        @(negedge clk);
        abort = 0;
        checks++; if ({busy, wr_valid, rd_en} !== 3'b0) begin errors++; $display("FAIL abort_stop got %b want 000", {busy, wr_valid, rd_en}); end
        repeat (6) @(negedge clk);
        checks++; if (wa_q.size() != 2 || done_cyc.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL abort_after got wr=%0d done=%0d busy=%b want 2/0/0", wa_q.size(), done_cyc.size(), busy); end
    endtask

    task automatic test_async_reset;
        bit ok;
        wr_ready = 0;
        go(3, 10'h100, 10'h100);
        wait_wr(20, 0, ok);
        checks++; if (!ok || xf_filter === 72'h0) begin errors++; $display("FAIL arst_setup got v=%b xf=%h want 1/nonzero", wr_valid, xf_filter); end
        #2 rstn = 0;
        #1;
        checks++; if ({rd_en, wr_valid, busy, done} !== 4'b0 || rd_addr !== 10'h0 || wr_addr !== 10'h0) begin errors++; $display("FAIL arst_ctrl got %b %h %h want 0000 0 0", {rd_en, wr_valid, busy, done}, rd_addr, wr_addr); end
        checks++; if (wr_data !== 128'h0 || xf_filter !== 72'h0) begin errors++; $display("FAIL arst_data got %h/%h want 0/0", wr_data, xf_filter); end
        @(negedge clk);
        rstn = 1;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0 || done_cyc.size() != 0) begin errors++; $display("FAIL arst_after got busy=%b done=%0d want 0/0", busy, done_cyc.size()); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_multi;
        test_backpressure;
        test_zero;
        test_wrap;
        test_abort;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
